status_stack_ctrl: RTL and testbench

- Owns the CPU's 32-bit nested status register, organised as a stack of 4-bit fields; field 0 is the current mode and the upper fields are saved contexts.
- Sequences exception-entry pushes (shift left, zero-filled), exception-return pops (shift right, zero-filled) and software full writes.
- Arbitrates between these three requesters with a req/ack handshake.
- Sits beside the CP0 register file; drives the interrupt-enable and user-mode controls for the pipeline.

---
 rtl/status_pkg.sv | 15 +
 rtl/status_field_shifter.sv | 12 +
 rtl/status_stack_ctrl.sv | 136 +++++++++++++
 tb/tb_status_stack_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/status_pkg.sv
// Shared constants and FSM state type for the nested status register controller.
package status_pkg;
    localparam int STATUS_W     = 32;
    localparam int STATUS_FIELD = 4;
    localparam int STATUS_DEPTH = STATUS_W / STATUS_FIELD;
    localparam int IE_BIT       = 0;
    localparam int UM_BIT       = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PUSH,
        ST_POP,
        ST_WRITE
    } state_t;
endpackage

// File: rtl/status_field_shifter.sv
// Zero-filled whole-field shifts of the status stack: left for push, right for pop.
module status_field_shifter #(
    parameter int WIDTH = 32,
    parameter int FIELD = 4
) (
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] shl,
    output logic [WIDTH-1:0] shr
);
    assign shl = {din[WIDTH-FIELD-1:0], {FIELD{1'b0}}};
    assign shr = {{FIELD{1'b0}}, din[WIDTH-1:FIELD]};
endmodule

// File: rtl/status_stack_ctrl.sv
// Nested status register: arbitrates push / write / pop requests and applies them one per op.
// state    | meaning
// IDLE     | sample requests, grant exc > wr > eret
// PUSH     | shift status left one field, depth+1 (saturating), exc_ack high
// POP      | shift status right one field if depth>0 else flag underflow, eret_ack high
// WRITE    | load wr_data into status, wr_ack high
module status_stack_ctrl
    import status_pkg::*;
#(
    parameter int             WIDTH        = STATUS_W,
    parameter int             FIELD        = STATUS_FIELD,
    parameter int             DEPTH        = WIDTH / FIELD,
    parameter logic [WIDTH-1:0] RESET_STATUS = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             exc_req,
    output logic             exc_ack,
    input  logic             eret_req,
    output logic             eret_ack,
    input  logic             wr_req,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_ack,
    input  logic             clr_flags,
    output logic [WIDTH-1:0] status,
    output logic             int_en,
    output logic             user_mode,
    output logic [3:0]       depth,
    output logic             ovf,
    output logic             unf
);
    localparam logic [3:0] DEPTH_MAX = 4'(DEPTH);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic [3:0]       depth_q, depth_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             exc_ack_q, exc_ack_d;
    logic             eret_ack_q, eret_ack_d;
    logic             wr_ack_q, wr_ack_d;
    logic             ovf_set, unf_set;
    logic [WIDTH-1:0] status_shl, status_shr;

    status_field_shifter #(
        .WIDTH (WIDTH),
        .FIELD (FIELD)
    ) u_shifter (
        .din (status_q),
        .shl (status_shl),
        .shr (status_shr)
    );

    // Acks are registered at grant time so they coincide with the op cycle.
    always_comb begin
        state_d    = state_q;
        status_d   = status_q;
        depth_d    = depth_q;
        exc_ack_d  = 1'b0;
        eret_ack_d = 1'b0;
        wr_ack_d   = 1'b0;
        ovf_set    = 1'b0;
        unf_set    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (exc_req) begin
                    state_d   = ST_PUSH;
                    exc_ack_d = 1'b1;
                end else if (wr_req) begin
                    state_d  = ST_WRITE;
                    wr_ack_d = 1'b1;
                end else if (eret_req) begin
                    state_d    = ST_POP;
                    eret_ack_d = 1'b1;
                end
            end
            ST_PUSH: begin
                state_d  = ST_IDLE;
                status_d = status_shl;
                if (depth_q == DEPTH_MAX) begin
                    ovf_set = 1'b1;
                end else begin
                    depth_d = depth_q + 4'd1;
                end
            end
            ST_POP: begin
                state_d = ST_IDLE;
                if (depth_q != 4'd0) begin
                    status_d = status_shr;
                    depth_d  = depth_q - 4'd1;
                end else begin
                    unf_set = 1'b1;
                end
            end
            ST_WRITE: begin
                state_d  = ST_IDLE;
                status_d = wr_data;
            end
            default: state_d = ST_IDLE;
        endcase
        // A setting event in the same cycle beats clr_flags.
        ovf_d = ovf_set | (ovf_q & ~clr_flags);
        unf_d = unf_set | (unf_q & ~clr_flags);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            status_q   <= RESET_STATUS;
            depth_q    <= 4'd0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            exc_ack_q  <= 1'b0;
            eret_ack_q <= 1'b0;
            wr_ack_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            depth_q    <= depth_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            exc_ack_q  <= exc_ack_d;
            eret_ack_q <= eret_ack_d;
            wr_ack_q   <= wr_ack_d;
        end
    end

    assign status    = status_q;
    assign depth     = depth_q;
    assign ovf       = ovf_q;
    assign unf       = unf_q;
    assign exc_ack   = exc_ack_q;
    assign eret_ack  = eret_ack_q;
    assign wr_ack    = wr_ack_q;
    assign int_en    = status_q[IE_BIT];
    assign user_mode = status_q[UM_BIT];
endmodule

// File: tb/tb_status_stack_ctrl.sv
// Self-checking bench for status_stack_ctrl: directed steps plus random ops against a stack model.
module tb_status_stack_ctrl;
    import status_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        exc_req, eret_req, wr_req, clr_flags;
    logic [31:0] wr_data;
    logic        exc_ack, eret_ack, wr_ack;
    logic [31:0] status;
    logic        int_en, user_mode, ovf, unf;
    logic [3:0]  depth;

    int tests = 0;
    int fails = 0;

    // Reference model: status as a plain word, depth as a count of saved contexts.
    logic [31:0] m_status;
    int          m_depth;
    logic        m_ovf, m_unf;

    status_stack_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .exc_req   (exc_req),
        .exc_ack   (exc_ack),
        .eret_req  (eret_req),
        .eret_ack  (eret_ack),
        .wr_req    (wr_req),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack),
        .clr_flags (clr_flags),
        .status    (status),
        .int_en    (int_en),
        .user_mode (user_mode),
        .depth     (depth),
        .ovf       (ovf),
        .unf       (unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, ":status"}, status, m_status);
        chk({tag, ":depth"}, {28'b0, depth}, 32'(m_depth));
        chk({tag, ":ovf"}, {31'b0, ovf}, {31'b0, m_ovf});
        chk({tag, ":unf"}, {31'b0, unf}, {31'b0, m_unf});
        chk({tag, ":int_en"}, {31'b0, int_en}, {31'b0, m_status[0]});
        chk({tag, ":user_mode"}, {31'b0, user_mode}, {31'b0, m_status[1]});
    endtask

    // kind: 0 = exception push, 1 = software write, 2 = exception return pop
    task automatic model_apply(input int kind, input logic [31:0] data);
        case (kind)
            0: begin
                if (m_depth == 8) m_ovf = 1'b1;
                else m_depth++;
                m_status = m_status << 4;
            end
            1: m_status = data;
            default: begin
                if (m_depth > 0) begin
                    m_status = m_status >> 4;
                    m_depth--;
                end else begin
                    m_unf = 1'b1;
                end
            end
        endcase
    endtask

    task automatic model_reset();
        m_status = 32'h0;
        m_depth  = 0;
        m_ovf    = 1'b0;
        m_unf    = 1'b0;
    endtask

    task automatic do_op(input int kind, input logic [31:0] data, input string tag);
        int       waited;
        logic     got;
        logic [2:0] want;
        want = 3'b100 >> kind;
        @(posedge clk); #1;
        case (kind)
            0: exc_req = 1'b1;
            1: begin wr_req = 1'b1; wr_data = data; end
            default: eret_req = 1'b1;
        endcase
        waited = 0;
        got    = 1'b0;
        while (!got && waited < 10) begin
            @(negedge clk);
            waited++;
            if (({exc_ack, wr_ack, eret_ack} & want) != 3'b000) got = 1'b1;
        end
        chk({tag, ":ack_latency"}, 32'(waited), 32'd2);
        chk({tag, ":ack_onehot"}, {29'b0, exc_ack, wr_ack, eret_ack}, {29'b0, want});
        @(posedge clk); #1;
        exc_req  = 1'b0;
        wr_req   = 1'b0;
        eret_req = 1'b0;
        model_apply(kind, data);
        @(negedge clk);
        chk({tag, ":ack_pulse"}, {29'b0, exc_ack, wr_ack, eret_ack}, 32'd0);
        check_state(tag);
    endtask

    task automatic clear_flags(input string tag);
        @(posedge clk); #1;
        clr_flags = 1'b1;
        @(posedge clk); #1;
        clr_flags = 1'b0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(negedge clk);
        check_state(tag);
    endtask

    initial begin
        int          ack_cyc [3];
        logic [31:0] d;
        rst       = 1'b1;
        exc_req   = 1'b0;
        eret_req  = 1'b0;
        wr_req    = 1'b0;
        clr_flags = 1'b0;
        wr_data   = 32'h0;
        model_reset();

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_state("reset");
        chk("reset:acks", {29'b0, exc_ack, wr_ack, eret_ack}, 32'd0);

        do_op(1, 32'h0000_0003, "write3");
        do_op(0, 32'h0, "push1");
        chk("push1:value", status, 32'h0000_0030);
        do_op(2, 32'h0, "pop1");
        chk("pop1:value", status, 32'h0000_0003);
        chk("pop1:ie", {31'b0, int_en}, 32'd1);
        chk("pop1:um", {31'b0, user_mode}, 32'd1);

        do_op(2, 32'h0, "underflow");
        chk("underflow:unf", {31'b0, unf}, 32'd1);
        clear_flags("clr_unf");

        do_op(1, 32'h0000_0001, "write1");
        for (int i = 0; i < 9; i++) do_op(0, 32'h0, "ovf_push");
        chk("ovf:depth", {28'b0, depth}, 32'd8);
        chk("ovf:flag", {31'b0, ovf}, 32'd1);
        chk("ovf:status", status, 32'h0);
        clear_flags("clr_ovf");

        // All three requesters at once: grants must follow exc, wr, eret order.
        do_op(1, 32'h0000_00A5, "pre_arb");
        d = $urandom;
        @(posedge clk); #1;
        exc_req  = 1'b1;
        wr_req   = 1'b1;
        eret_req = 1'b1;
        wr_data  = d;
        for (int k = 0; k < 3; k++) ack_cyc[k] = -1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (exc_ack  && ack_cyc[0] < 0) ack_cyc[0] = c;
            if (wr_ack   && ack_cyc[1] < 0) ack_cyc[1] = c;
            if (eret_ack && ack_cyc[2] < 0) ack_cyc[2] = c;
            @(posedge clk); #1;
            if (ack_cyc[0] == c) exc_req  = 1'b0;
            if (ack_cyc[1] == c) wr_req   = 1'b0;
            if (ack_cyc[2] == c) eret_req = 1'b0;
        end
        exc_req  = 1'b0;
        wr_req   = 1'b0;
        eret_req = 1'b0;
        chk("arb:exc_cycle", 32'(ack_cyc[0]), 32'd1);
        chk("arb:wr_cycle", 32'(ack_cyc[1]), 32'd3);
        chk("arb:eret_cycle", 32'(ack_cyc[2]), 32'd5);
        model_apply(0, 32'h0);
        model_apply(1, d);
        model_apply(2, 32'h0);
        @(negedge clk);
        check_state("arb");
        chk("arb:final", status, d >> 4);

        for (int i = 0; i < 40; i++) begin
            int kind;
            kind = int'($urandom_range(0, 2));
            do_op(kind, $urandom, "rand");
            if ($urandom_range(0, 7) == 0) clear_flags("rand_clr");
        end

        // Reset arriving with a pending request wins and produces no ack.
        @(posedge clk); #1;
        exc_req = 1'b1;
        rst     = 1'b1;
        @(posedge clk); #1;
        exc_req = 1'b0;
        rst     = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_mid:acks", {29'b0, exc_ack, wr_ack, eret_ack}, 32'd0);
        check_state("rst_mid");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
